// File: rtl/axi_test_sequencer_pkg.sv
// State encoding and state-class helpers shared by the AXI test sequencer blocks.
package axi_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DELAY     = 3'd1,
    ST_PULSE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4,
    ST_FINISH    = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  function automatic logic is_active(input state_t s);
    return (s == ST_DELAY) || (s == ST_PULSE) || (s == ST_WAIT_DONE) || (s == ST_GAP);
  endfunction

  // States that wait for a start request.
  function automatic logic is_parked(input state_t s);
    return (s == ST_IDLE) || (s == ST_FINISH) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/test_cycle_counter.sv
// Loadable down-counter used for DELAY/PULSE/GAP timing and the WAIT_DONE watchdog.
// Load has priority; otherwise the count decrements and holds at zero.
module test_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/axi_test_sequencer.sv
// Issues NUM_TX init_tx pulses with programmable lead-in, pulse width and gap, waiting for
// tx_done between them; start is registered once, so init_tx rises START_DELAY+1 edges after it.
module axi_test_sequencer
  import axi_test_sequencer_pkg::*;
#(
  parameter int NUM_TX      = 4,
  parameter int START_DELAY = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int PULSE_WIDTH = 1,
  parameter int TIMEOUT     = 256,
  parameter int AUTO_START  = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tx_done,
  output logic             init_tx,
  output logic             busy,
  output logic             seq_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] tx_count
);

  // Each phase loads N-1 so that the phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] WDOG_LD  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(NUM_TX);

  state_t           state;
  state_t           next_state;
  logic             start_q;
  logic             done_seen;
  logic             complete;
  logic             cnt_load;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] count_inc;

  test_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cycle_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign count_inc = (tx_count == '1) ? tx_count : tx_count + CNT_W'(1);

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    case (state)
      ST_IDLE, ST_FINISH, ST_ERROR: begin
        if (start_q || (state == ST_IDLE && AUTO_START != 0)) begin
          if (START_DELAY > 0) next_state = ST_DELAY;
          else                 next_state = ST_PULSE;
        end
      end
      ST_DELAY, ST_GAP: begin
        if (cnt_zero) next_state = ST_PULSE;
      end
      ST_PULSE: begin
        // A fast master may answer while the pulse is still high.
        if (cnt_zero) begin
          if (done_seen || tx_done) complete   = 1'b1;
          else                      next_state = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done)                         complete   = 1'b1;
        else if (TIMEOUT != 0 && cnt_zero)   next_state = ST_ERROR;
      end
      default: next_state = ST_IDLE;
    endcase
    if (complete) begin
      if (count_inc == LAST_TX)  next_state = ST_FINISH;
      else if (GAP_CYCLES > 0)   next_state = ST_GAP;
      else                       next_state = ST_PULSE;
    end
  end

  always_comb begin
    cnt_load = (next_state != state) || complete;
    cnt_val  = '0;
    case (next_state)
      ST_DELAY:     cnt_val = DELAY_LD;
      ST_PULSE:     cnt_val = PULSE_LD;
      ST_GAP:       cnt_val = GAP_LD;
      ST_WAIT_DONE: cnt_val = WDOG_LD;
      default:      cnt_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      done_seen   <= 1'b0;
      init_tx     <= 1'b0;
      busy        <= 1'b0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
      tx_count    <= '0;
    end else begin
      state       <= next_state;
      start_q     <= start;
      done_seen   <= (state == ST_PULSE) && (next_state == ST_PULSE) && !complete &&
                     (done_seen || tx_done);
      init_tx     <= (next_state == ST_PULSE);
      busy        <= is_active(next_state);
      seq_done    <= (next_state == ST_FINISH);
      timeout_err <= (next_state == ST_ERROR);
      if (is_parked(state) && next_state != state) tx_count <= '0;
      else if (complete)                            tx_count <= count_inc;
    end
  end

endmodule

// File: tb/tb_axi_test_sequencer.sv
// Bench for axi_test_sequencer: an auto-start single-transaction instance and a
// start-triggered four-transaction instance with a short watchdog.
module tb_axi_test_sequencer;

  localparam int CW   = 16;
  localparam int N_B  = 4;
  localparam int SD_B = 8;
  localparam int GAP_B = 16;
  localparam int PW_B = 2;
  localparam int TO_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, start_a, tx_done_a, init_a, busy_a, done_a, err_a;
  logic [CW-1:0] cnt_a;
  logic          rst_b, start_b, tx_done_b, init_b, busy_b, done_b, err_b;
  logic [CW-1:0] cnt_b;

  axi_test_sequencer #(
    .NUM_TX(1), .START_DELAY(0), .GAP_CYCLES(16), .PULSE_WIDTH(1),
    .TIMEOUT(256), .AUTO_START(1), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .tx_done(tx_done_a), .init_tx(init_a),
    .busy(busy_a), .seq_done(done_a), .timeout_err(err_a), .tx_count(cnt_a)
  );

  axi_test_sequencer #(
    .NUM_TX(N_B), .START_DELAY(SD_B), .GAP_CYCLES(GAP_B), .PULSE_WIDTH(PW_B),
    .TIMEOUT(TO_B), .AUTO_START(0), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .tx_done(tx_done_b), .init_tx(init_b),
    .busy(busy_b), .seq_done(done_b), .timeout_err(err_b), .tx_count(cnt_b)
  );

  typedef struct {
    int d0, d1, d2, d3;
    bit extra;
    int exp_rise, exp_end, exp_cnt;
    bit exp_done, exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pk(input logic i, input logic b, input logic d, input logic e,
                            input logic [CW-1:0] c);
    return {12'd0, i, b, d, e, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one sequence on dut_b (start sampled at edge 0) and checks every cycle against
  // a timeline derived from the transaction rules: rise, completion and end edges.
  task automatic run_b(input int d0, input int d1, input int d2, input int d3, input bit extra,
                       output int rise, output int fin, output int cnt,
                       output bit dn, output bit er);
    int dl[4];
    int r[4];
    int c[4];
    bit sched[256];
    int n_start, n_done, end_e, rr, e, tlim, exp_cnt;
    bit failed, exp_init;
    dl = '{d0, d1, d2, d3};
    foreach (sched[i]) sched[i] = 1'b0;
    foreach (r[i]) begin r[i] = 0; c[i] = 0; end
    n_start = 0; n_done = 0; failed = 1'b0; end_e = 0;
    rr = 1 + SD_B;
    for (int i = 0; i < N_B; i++) begin
      r[i] = rr;
      n_start++;
      e = rr + dl[i] + 1;
      if (e > rr + PW_B + TO_B) begin
        failed = 1'b1;
        end_e  = rr + PW_B + TO_B;
        break;
      end
      sched[e] = 1'b1;
      c[i]  = (e > rr + PW_B) ? e : rr + PW_B;
      n_done++;
      end_e = c[i];
      rr    = c[i] + GAP_B;
    end
    if (extra) begin
      sched[r[0] - 3] = 1'b1;
      for (int i = 0; i < n_done; i++) if (c[i] < end_e) sched[c[i] + 5] = 1'b1;
      sched[end_e + 2] = 1'b1;
    end
    tlim = end_e + 4;
    rise = -1;
    fin  = -1;
    start_b   = 1'b1;
    tx_done_b = sched[0];
    for (int t = 0; t <= tlim; t++) begin
      step();
      if (t >= 1) begin
        exp_init = 1'b0;
        for (int i = 0; i < n_start; i++) if (t >= r[i] && t < r[i] + PW_B) exp_init = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < n_done; i++) if (c[i] <= t) exp_cnt++;
        check($sformatf("b_cycle_%0d", t), pk(init_b, busy_b, done_b, err_b, cnt_b),
              pk(exp_init, t < end_e, !failed && t >= end_e, failed && t >= end_e,
                 exp_cnt[CW-1:0]));
        if (init_b && rise < 0) rise = t;
        if (!busy_b && fin < 0) fin = t;
      end
      start_b   = 1'b0;
      tx_done_b = sched[t + 1];
    end
    tx_done_b = 1'b0;
    cnt = int'(cnt_b);
    dn  = done_b;
    er  = err_b;
  endtask

  initial begin
    vec_t tbl[6];
    int   seen, rise, fin, cnt;
    bit   dn, er;

    tbl[0] = '{0, 0, 0, 0, 1'b0, 9, 65, 4, 1'b1, 1'b0};
    tbl[1] = '{3, 5, 1, 9, 1'b1, 9, 79, 4, 1'b1, 1'b0};
    tbl[2] = '{2, 20, 0, 0, 1'b1, 9, 40, 1, 1'b0, 1'b1};
    tbl[3] = '{20, 0, 0, 0, 1'b0, 9, 21, 0, 1'b0, 1'b1};
    tbl[4] = '{11, 11, 11, 11, 1'b0, 9, 105, 4, 1'b1, 1'b0};
    tbl[5] = '{1, 12, 0, 0, 1'b1, 9, 39, 1, 1'b0, 1'b1};

    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    tx_done_a = 1'b0; tx_done_b = 1'b0;
    step();
    step();
    check("reset_a", pk(init_a, busy_a, done_a, err_a, cnt_a), 0);
    check("reset_b", pk(init_b, busy_b, done_b, err_b, cnt_b), 0);

    // Auto-start, single transaction, completion three cycles after the pulse.
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    check("a_first_pulse", pk(init_a, busy_a, done_a, err_a, cnt_a), pk(1, 1, 0, 0, 0));
    step();
    check("a_wait_done", pk(init_a, busy_a, done_a, err_a, cnt_a), pk(0, 1, 0, 0, 0));
    step();
    step();
    check("a_still_busy", pk(init_a, busy_a, done_a, err_a, cnt_a), pk(0, 1, 0, 0, 0));
    tx_done_a = 1'b1;
    step();
    tx_done_a = 1'b0;
    check("a_seq_done", pk(init_a, busy_a, done_a, err_a, cnt_a), pk(0, 0, 1, 0, 1));
    repeat (5) step();
    check("a_finish_hold", pk(init_a, busy_a, done_a, err_a, cnt_a), pk(0, 0, 1, 0, 1));
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("a_start_sampled", pk(init_a, busy_a, done_a, err_a, cnt_a), pk(0, 0, 1, 0, 1));
    step();
    check("a_restart_pulse", pk(init_a, busy_a, done_a, err_a, cnt_a), pk(1, 1, 0, 0, 0));
    #2 rst_a = 1'b0;
    #1;
    check("a_async_reset", pk(init_a, busy_a, done_a, err_a, cnt_a), 0);
    @(posedge clk);
    #1 rst_a = 1'b1;
    step();
    check("a_pulse_after_reset", pk(init_a, busy_a, done_a, err_a, cnt_a), pk(1, 1, 0, 0, 0));

    // No auto-start on dut_b while start stays low.
    seen = 0;
    repeat (100) begin
      step();
      if (init_b || busy_b) seen++;
    end
    check("b_no_autostart", seen, 0);

    for (int k = 0; k < 6; k++) begin
      run_b(tbl[k].d0, tbl[k].d1, tbl[k].d2, tbl[k].d3, tbl[k].extra, rise, fin, cnt, dn, er);
      check($sformatf("tbl%0d_rise", k), rise, tbl[k].exp_rise);
      check($sformatf("tbl%0d_end", k), fin, tbl[k].exp_end);
      check($sformatf("tbl%0d_count", k), cnt, tbl[k].exp_cnt);
      check($sformatf("tbl%0d_seq_done", k), int'(dn), int'(tbl[k].exp_done));
      check($sformatf("tbl%0d_timeout_err", k), int'(er), int'(tbl[k].exp_err));
    end

    for (int k = 0; k < 10; k++) begin
      run_b(int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
            int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
            1'($urandom_range(0, 1)), rise, fin, cnt, dn, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
